ysyx_22040759_ifu: RTL and testbench

Instruction fetch unit upstream of the single-cycle core's decode/execute path. It replaces the combinational instruction ROM lookup.
- Owns the fetch PC and issues in-order 32-bit fetch requests on a valid/ready SRAM-style port.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Flushes on redirect from the branch/jump unit.

---
 rtl/ysyx_22040759_ifu_pkg.sv | 27 ++
 rtl/ysyx_22040759_ifu_fifo.sv | 90 +++++++++
 rtl/ysyx_22040759_ifu.sv | 167 ++++++++++++++++
 tb/tb_ysyx_22040759_ifu.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040759_ifu_pkg.sv
// Shared constants and helpers for the instruction fetch unit.
//   ILEN            instruction word width
//   IFU_XLEN        default address width
//   IFU_RESET_PC    default first fetch address after reset
//   IFU_DEPTH       default credit depth (FIFO entries / outstanding requests)
//   ST_IDLE/ST_RUN  fetch control states
package ysyx_22040759_ifu_pkg;

    localparam int unsigned     ILEN         = 32;
    localparam int unsigned     IFU_XLEN     = 64;
    localparam int unsigned     IFU_DEPTH    = 2;
    localparam logic [63:0]     IFU_RESET_PC = 64'h0000_0000_8000_0000;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width for a circular buffer; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ysyx_22040759_ifu_fifo.sv
// Circular buffer with push/pop/flush used for both the instruction FIFO and
// the PC tag queue.
//   clk, rst_n   clock, async active-low reset (storage cleared to zero)
//   push_i       write wdata_i (accepted when not full, or full with pop_i)
//   pop_i        advance the head (ignored when empty)
//   flush_i      discard all contents; wins over push/pop
//   rdata_o      head entry (holds while not popped)
//   count_o      number of valid entries
//   empty_o      no valid entries
//   full_o       DEPTH valid entries
module ysyx_22040759_ifu_fifo
    import ysyx_22040759_ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               wdata_i,
    input  logic                           pop_i,
    input  logic                           flush_i,
    output logic [WIDTH-1:0]               rdata_o,
    output logic [cnt_width(DEPTH)-1:0]    count_o,
    output logic                           empty_o,
    output logic                           full_o
);

    localparam int unsigned      CNT_W = cnt_width(DEPTH);
    localparam int unsigned      PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointer and occupancy update.
    always_comb begin
        do_pop   = pop_i & ~flush_i & (count_q != '0);
        do_push  = push_i & ~flush_i & ((count_q != CNT_W'(DEPTH)) | do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/ysyx_22040759_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues in-order fetch requests,
// buffers returned words with their PCs and hands them to decode.
//   clk, rst                    clock, async active-low reset
//   halt                        stop issuing new requests
//   redirect_valid/redirect_pc  restart the fetch stream (low two bits ignored)
//   req_valid/req_ready/req_addr  fetch request port
//   rsp_valid/rsp_data          in-order fetch responses, always accepted
//   inst_valid/inst_ready/inst/inst_pc  instruction stream to decode
module ysyx_22040759_ifu
    import ysyx_22040759_ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = IFU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC,
    parameter int unsigned     DEPTH    = IFU_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [XLEN-1:0]  req_addr,
    input  logic             rsp_valid,
    input  logic [ILEN-1:0]  rsp_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [ILEN-1:0]  inst,
    output logic [XLEN-1:0]  inst_pc
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam int unsigned ENT_W = ILEN + XLEN;

    logic [0:0]       state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             running, credit_ok;
    logic             req_fire, rsp_ok, rsp_drop;
    logic             tag_push, tag_pop, tag_empty, tag_full;
    logic [CNT_W-1:0] tag_count;
    logic [XLEN-1:0]  tag_pc;
    logic             inst_push, inst_pop, inst_empty, inst_full;
    logic [CNT_W-1:0] inst_count;
    logic [ENT_W-1:0] inst_wdata, inst_rdata;

    // Control state: one idle cycle out of reset, then run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and issue decision; outstanding requests plus buffered
    // words share DEPTH credits so a response always finds a FIFO slot.
    always_comb begin
        state_d   = state_q;
        running   = 1'b0;
        credit_ok = ((CNT_W + 1)'(outstanding_q) + (CNT_W + 1)'(inst_count))
                    < (CNT_W + 1)'(DEPTH);
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN:  running = 1'b1;
            default: state_d = ST_IDLE;
        endcase
        req_valid = running & ~halt & ~redirect_valid & credit_ok;
    end

    // Handshake qualifiers; a response with nothing outstanding is ignored.
    always_comb begin
        req_fire   = req_valid & req_ready;
        rsp_ok     = rsp_valid & (outstanding_q != '0);
        rsp_drop   = rsp_ok & (drop_cnt_q != '0);
        tag_push   = req_fire;
        tag_pop    = rsp_ok & ~rsp_drop & ~redirect_valid;
        inst_push  = tag_pop;
        inst_pop   = inst_valid & inst_ready & ~redirect_valid;
        inst_wdata = {rsp_data, tag_pc};
    end

    // Fetch PC, outstanding and drop counters; redirect overrides everything.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_ok);
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            // Everything still in flight after this cycle belongs to the old stream.
            drop_cnt_d = outstanding_q - CNT_W'(rsp_ok);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // PCs of requests whose responses will be kept.
    ysyx_22040759_ifu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_tag_q (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (tag_push),
        .wdata_i (fetch_pc_q),
        .pop_i   (tag_pop),
        .flush_i (redirect_valid),
        .rdata_o (tag_pc),
        .count_o (tag_count),
        .empty_o (tag_empty),
        .full_o  (tag_full)
    );

    // Returned instruction words with their PCs.
    ysyx_22040759_ifu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_inst_q (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (inst_push),
        .wdata_i (inst_wdata),
        .pop_i   (inst_pop),
        .flush_i (redirect_valid),
        .rdata_o (inst_rdata),
        .count_o (inst_count),
        .empty_o (inst_empty),
        .full_o  (inst_full)
    );

    assign req_addr   = fetch_pc_q;
    assign inst_valid = ~inst_empty;
    assign inst       = inst_rdata[ENT_W-1:XLEN];
    assign inst_pc    = inst_rdata[XLEN-1:0];

    // Protocol and bookkeeping invariants.
    a_rsp_no_outstanding: assert property (@(posedge clk) disable iff (!rst)
        !(rsp_valid && outstanding_q == '0));
    a_tag_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(tag_push && tag_full));
    a_tag_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(tag_pop && tag_empty));
    a_inst_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(inst_push && inst_full && !inst_pop));
    a_tag_balance: assert property (@(posedge clk) disable iff (!rst)
        (tag_count + drop_cnt_q) == outstanding_q);

endmodule

// File: tb/tb_ysyx_22040759_ifu.sv
module tb_ysyx_22040759_ifu;

    logic        clk;
    logic        rst;
    logic        halt;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int hs_cnt  = 0;
    int mem_lat = 1;
    int hs0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;
    rsp_t pend_q[$];

    ysyx_22040759_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Fixed-latency memory: word returned is the bitwise inverse of the address.
    initial begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend_q.delete();
                rsp_valid = 1'b0;
                rsp_data  = '0;
            end else begin
                if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                    rsp_valid = 1'b1;
                    rsp_data  = pend_q[0].data;
                    void'(pend_q.pop_front());
                end else begin
                    rsp_valid = 1'b0;
                    rsp_data  = '0;
                end
                if (req_valid && req_ready) begin
                    rsp_t e;
                    e.due  = cyc + mem_lat;
                    e.data = ~req_addr[31:0];
                    pend_q.push_back(e);
                    hs_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Assert reset mid-cycle, check the immediate effect, release two cycles later.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, "_rst_req_valid"},  64'(req_valid),  64'd0);
        chk({tag, "_rst_inst_valid"}, 64'(inst_valid), 64'd0);
        chk({tag, "_rst_inst"},       64'(inst),       64'd0);
        chk({tag, "_rst_inst_pc"},    inst_pc,         64'd0);
        chk({tag, "_rst_req_addr"},   req_addr,        64'h8000_0000);
        next();
        next();
        rst = 1'b1;
    endtask

    initial begin
        rst            = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        req_ready      = 1'b0;
        inst_ready     = 1'b0;
        mem_lat        = 1;

        // Reset state
        sample();
        chk("reset_req_valid",  64'(req_valid),  64'd0);
        chk("reset_inst_valid", 64'(inst_valid), 64'd0);
        chk("reset_inst",       64'(inst),       64'd0);
        chk("reset_inst_pc",    inst_pc,         64'd0);
        chk("reset_req_addr",   req_addr,        64'h8000_0000);

        // Sequential stream with a 1-cycle memory
        next();
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        rst        = 1'b1;
        sample(); chk("p1_c0_req_valid", 64'(req_valid), 64'd0);
        next(); sample();
        chk("p1_c1_req_valid",  64'(req_valid),  64'd1);
        chk("p1_c1_req_addr",   req_addr,        64'h8000_0000);
        chk("p1_c1_inst_valid", 64'(inst_valid), 64'd0);
        next(); sample();
        chk("p1_c2_req_valid",  64'(req_valid),  64'd1);
        chk("p1_c2_req_addr",   req_addr,        64'h8000_0004);
        chk("p1_c2_inst_valid", 64'(inst_valid), 64'd0);
        next(); sample();
        chk("p1_c3_inst_valid", 64'(inst_valid), 64'd1);
        chk("p1_c3_inst_pc",    inst_pc,         64'h8000_0000);
        chk("p1_c3_inst",       64'(inst),       64'h7FFF_FFFF);
        chk("p1_c3_req_valid",  64'(req_valid),  64'd0);
        next(); sample();
        chk("p1_c4_inst_valid", 64'(inst_valid), 64'd1);
        chk("p1_c4_inst_pc",    inst_pc,         64'h8000_0004);
        chk("p1_c4_inst",       64'(inst),       64'h7FFF_FFFB);
        chk("p1_c4_req_valid",  64'(req_valid),  64'd1);
        chk("p1_c4_req_addr",   req_addr,        64'h8000_0008);
        next();

        // Decode stalled: credits fill, then drain and resume
        inst_ready = 1'b0;
        mem_lat    = 1;
        do_reset("p2");
        hs0 = hs_cnt;
        for (int i = 0; i < 10; i++) next();
        sample();
        chk("p2_full_req_valid",  64'(req_valid),  64'd0);
        chk("p2_full_inst_valid", 64'(inst_valid), 64'd1);
        chk("p2_full_inst_pc",    inst_pc,         64'h8000_0000);
        next();
        chk("p2_req_count", 64'(hs_cnt - hs0), 64'd2);
        inst_ready = 1'b1;
        sample();
        chk("p2_c11_inst_pc",   inst_pc,        64'h8000_0000);
        chk("p2_c11_req_valid", 64'(req_valid), 64'd0);
        next(); sample();
        chk("p2_c12_req_valid", 64'(req_valid), 64'd1);
        chk("p2_c12_req_addr",  req_addr,       64'h8000_0008);
        chk("p2_c12_inst_pc",   inst_pc,        64'h8000_0004);
        chk("p2_c12_inst",      64'(inst),      64'h7FFF_FFFB);
        next();

        // Redirect with two requests in flight, 3-cycle memory
        inst_ready = 1'b1;
        mem_lat    = 3;
        do_reset("p3");
        next(); next(); next();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0101;
        sample(); chk("p3_c3_req_valid", 64'(req_valid), 64'd0);
        next();
        redirect_valid = 1'b0;
        sample();
        chk("p3_c4_req_valid",  64'(req_valid),  64'd0);
        chk("p3_c4_req_addr",   req_addr,        64'h8000_0100);
        chk("p3_c4_inst_valid", 64'(inst_valid), 64'd0);
        next(); sample();
        chk("p3_c5_req_valid",  64'(req_valid),  64'd1);
        chk("p3_c5_req_addr",   req_addr,        64'h8000_0100);
        chk("p3_c5_inst_valid", 64'(inst_valid), 64'd0);
        next(); sample();
        chk("p3_c6_inst_valid", 64'(inst_valid), 64'd0);
        next(); next(); sample();
        chk("p3_c8_inst_valid", 64'(inst_valid), 64'd0);
        next(); sample();
        chk("p3_c9_inst_valid", 64'(inst_valid), 64'd1);
        chk("p3_c9_inst_pc",    inst_pc,         64'h8000_0100);
        chk("p3_c9_inst",       64'(inst),       64'h7FFF_FEFF);
        next();

        // Redirect coinciding with a response and a pop; then with free credit
        inst_ready = 1'b1;
        mem_lat    = 1;
        do_reset("p4");
        next(); next(); next();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        sample();
        chk("p4_c3_inst_valid", 64'(inst_valid), 64'd1);
        chk("p4_c3_req_valid",  64'(req_valid),  64'd0);
        next();
        redirect_valid = 1'b0;
        sample();
        chk("p4_c4_inst_valid", 64'(inst_valid), 64'd0);
        chk("p4_c4_req_valid",  64'(req_valid),  64'd1);
        chk("p4_c4_req_addr",   req_addr,        64'h8000_0200);
        next(); sample();
        chk("p4_c5_req_addr",   req_addr,        64'h8000_0204);
        chk("p4_c5_inst_valid", 64'(inst_valid), 64'd0);
        next(); sample();
        chk("p4_c6_inst_valid", 64'(inst_valid), 64'd1);
        chk("p4_c6_inst_pc",    inst_pc,         64'h8000_0200);
        chk("p4_c6_inst",       64'(inst),       64'h7FFF_FDFF);
        next();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0303;
        sample();
        chk("p4_c7_req_valid", 64'(req_valid), 64'd0);
        chk("p4_c7_inst_pc",   inst_pc,        64'h8000_0204);
        next();
        redirect_valid = 1'b0;
        sample();
        chk("p4_c8_req_valid",  64'(req_valid),  64'd1);
        chk("p4_c8_req_addr",   req_addr,        64'h8000_0300);
        chk("p4_c8_inst_valid", 64'(inst_valid), 64'd0);
        next();

        // Halt mid-stream
        inst_ready = 1'b1;
        mem_lat    = 1;
        do_reset("p5");
        next(); sample();
        chk("p5_c1_req_valid", 64'(req_valid), 64'd1);
        chk("p5_c1_req_addr",  req_addr,       64'h8000_0000);
        next();
        halt = 1'b1;
        sample(); chk("p5_c2_req_valid", 64'(req_valid), 64'd0);
        next(); sample();
        chk("p5_c3_inst_valid", 64'(inst_valid), 64'd1);
        chk("p5_c3_inst_pc",    inst_pc,         64'h8000_0000);
        chk("p5_c3_req_valid",  64'(req_valid),  64'd0);
        next(); sample();
        chk("p5_c4_inst_valid", 64'(inst_valid), 64'd0);
        chk("p5_c4_req_valid",  64'(req_valid),  64'd0);
        chk("p5_c4_req_addr",   req_addr,        64'h8000_0004);
        next();
        halt = 1'b0;
        sample();
        chk("p5_c5_req_valid", 64'(req_valid), 64'd1);
        chk("p5_c5_req_addr",  req_addr,       64'h8000_0004);
        next(); next(); sample();
        chk("p5_c7_inst_valid", 64'(inst_valid), 64'd1);
        chk("p5_c7_inst_pc",    inst_pc,         64'h8000_0004);
        next();

        // Reset pulse with two requests outstanding, then clean restart
        inst_ready = 1'b1;
        mem_lat    = 3;
        do_reset("p6a");
        next(); next(); next();
        do_reset("p6b");
        next(); sample();
        chk("p6_c1_req_valid", 64'(req_valid), 64'd1);
        chk("p6_c1_req_addr",  req_addr,       64'h8000_0000);
        next(); next(); next(); sample();
        chk("p6_c4_inst_valid", 64'(inst_valid), 64'd0);
        next(); sample();
        chk("p6_c5_inst_valid", 64'(inst_valid), 64'd1);
        chk("p6_c5_inst_pc",    inst_pc,         64'h8000_0000);
        chk("p6_c5_inst",       64'(inst),       64'h7FFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
